leaf_out_arbiter: RTL
=====================

Name: leaf_out_arbiter

Overview:
- Shares the single leaf-to-BFT output link between NUM_OUT_PORTS user output streams.
- Streams use 32-bit payload with vld/ack handshakes. Per-port destination (leaf, port) comes from a config table.
- Per-port credits track remote BRAM freespace. Packets are formed as {1'b1, dest_leaf, dest_port, bram_addr, payload}.
- Sits between user_kernel outputs and the leaf's BFT-facing output register, at clk_400.

Parameters:
- NUM_OUT_PORTS, 6, number of user output streams (1..15)
- PACKET_BITS, 49, BFT packet width; must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, remote BRAM address field width
- FREESPACE_UPDATE_SIZE, 64, credits returned per credit_upd pulse
- MAX_BURST, 4, max consecutive accepts from one port before the grant rotates

Ports:
- clk  in  1  clock, clk_400 domain
- reset_n  in  1  asynchronous, active-low reset
- din_user  in  NUM_OUT_PORTS*PAYLOAD_BITS  payloads; port i occupies slice [i*32 +: 32]
- vld_user  in  NUM_OUT_PORTS  per-port data valid
- ack_user  out  NUM_OUT_PORTS  per-port accept; one-hot or zero
- cfg_we  in  1  config table write strobe
- cfg_port  in  NUM_PORT_BITS  table index to write
- cfg_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_dport  in  NUM_PORT_BITS  destination port
- credit_upd  in  NUM_OUT_PORTS  per-port freespace-return pulses
- resend  in  1  freeze: no new accepts while high
- pkt_out  out  PACKET_BITS  packet to BFT
- pkt_vld  out  1  pkt_out valid
- pkt_rdy  in  1  downstream accepts pkt_out this cycle

Behaviour:
- Reset values:
  - ack_user=0, pkt_vld=0, pkt_out=0
  - grant pointer=0, burst count=0
  - all cfg_valid=0
  - credits=2**NUM_ADDR_BITS
  - bram_addr counters=0
- Eligibility of port i requires all of:
  - vld_user[i]
  - cfg_valid[i]
  - credit[i]!=0
  - !resend
- out_free = !pkt_vld || pkt_rdy.
- ack_user[i] is combinational and equals (i==grant) && eligible(i) && out_free.
- Transfer happens on ack & vld. Latency is 1: the packet is registered into pkt_out/pkt_vld on the next edge.
- pkt_vld stays high and pkt_out stays stable until pkt_rdy.
- pkt_rdy with no new accept clears pkt_vld. Simultaneous drain and accept reloads pkt_out with pkt_vld held at 1.
- Arbiter states:
  - SCAN: if grant port is not eligible, advance grant to the next eligible port in round-robin order, searching from grant+1. At most one move per cycle. Stay in SCAN.
  - HOLD: entered on the first accept. burst_cnt counts accepts. Leave to SCAN with grant=grant+1 (mod NUM_OUT_PORTS) when either:
    - burst_cnt reaches MAX_BURST, or
    - the grant port is not eligible for one cycle.
- Credits:
  - Width is NUM_ADDR_BITS+1.
  - Accept decrements; credit_upd[i] adds FREESPACE_UPDATE_SIZE, saturating at 2**NUM_ADDR_BITS.
  - Simultaneous accept and update apply the net change in one cycle.
  - credit=0 blocks the port.
- bram_addr[i] increments per accept and wraps 2**NUM_ADDR_BITS-1 to 0.
- A cfg write sets cfg_valid, leaf and dport for cfg_port. It also resets that port's credit and bram_addr.
- cfg_port >= NUM_OUT_PORTS is ignored.
- A cfg write to the currently granted port suppresses that port's ack in the same cycle.
- resend: the grant and burst count freeze. An already-registered pkt_out still drains on pkt_rdy.
- Reset mid-operation: everything returns to reset values immediately. A pending packet is discarded.

Optional Feature:
- Macro: LEAF_OUT_ARBITER_STATS_EN.
- Defined: adds per-port 16-bit saturating stall counters, incremented each cycle vld_user[i] && !ack_user[i]. Also adds a 32-bit total-packet counter. Exposed on output stat_stall (NUM_OUT_PORTS*16) and stat_pkts (32). All clear on reset.
- Undefined: no counters and no stat ports.

Decomposition:
- Shared package holds:
  - packet field widths and bit-position localparams (VALID_POS, LEAF_LSB, PORT_LSB, ADDR_LSB)
  - the credit width function
  - the arbiter state encoding (SCAN, HOLD)
- Sub-module leaf_credit_cnt: one per port. Handles the credit counter with saturating add, decrement and cfg reload. Instantiated in a generate loop.

Test Plan:
- Config port0 with leaf=3, dport=2; push 0xDEADBEEF on port0 -> next cycle pkt_out={1,5'd3,4'd2,7'd0,32'hDEADBEEF}, pkt_vld=1.
- All 6 ports valid continuously, pkt_rdy=1, MAX_BURST=4 -> accepts in order 4x port0, 4x port1, ..., 4x port5, then port0 again; no idle cycles.
- Port2 sends 128 words with no credit_upd -> 129th is not acked, bram_addr wrapped to 0. One credit_upd[2] pulse -> acks resume; exactly 64 more accepted.
- Hold pkt_rdy=0 with data pending -> pkt_out stable, all ack_user=0. Release pkt_rdy -> same-cycle drain plus new accept with no bubble.
- Assert resend for 5 cycles mid-burst -> zero acks during the window; burst continues after release with remaining count intact.
- Assert reset_n low while pkt_vld=1 -> pkt_vld=0 and ack_user=0 asynchronously. After release, unconfigured ports are never acked.

Source files
------------

// File: rtl/leaf_out_arbiter_pkg.sv
// Shared packet layout, credit sizing and arbiter state encoding for the
// leaf-to-BFT output arbiter.
package leaf_out_arbiter_pkg;

    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

    // Packet layout, MSB first: {valid, dest_leaf, dest_port, bram_addr, payload}
    localparam int ADDR_LSB  = PAYLOAD_BITS;
    localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_POS = LEAF_LSB + NUM_LEAF_BITS;

    // One extra bit so a completely empty remote BRAM (2**addr_bits) is representable.
    function automatic int credit_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    localparam int CREDIT_BITS = credit_width(NUM_ADDR_BITS);
    localparam int CREDIT_MAX  = 2 ** NUM_ADDR_BITS;

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/leaf_out_arbiter_credit_cnt.sv
// Per-port remote-freespace credit counter: decrement on accept, saturating
// add on credit return, full reload on a config write.
module leaf_credit_cnt
    import leaf_out_arbiter_pkg::*;
#(
    parameter int UPDATE_SIZE = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   dec,
    input  logic                   upd,
    input  logic                   reload,
    output logic [CREDIT_BITS-1:0] credit
);

    localparam int EXT_W = CREDIT_BITS + 1;
    localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(CREDIT_MAX);
    localparam logic [EXT_W-1:0] UPD_EXT = EXT_W'(UPDATE_SIZE);

    logic [EXT_W-1:0]       sum;
    logic [CREDIT_BITS-1:0] credit_nxt;

    // NOTE: every branch of a combinational block must assign every output,
    // otherwise synthesis infers a latch; assigning first and overriding avoids that.
    always_comb begin
        sum = {1'b0, credit} + (upd ? UPD_EXT : '0) - {{CREDIT_BITS{1'b0}}, dec};
        if (reload || (sum > MAX_EXT)) credit_nxt = MAX_EXT[CREDIT_BITS-1:0];
        else                           credit_nxt = sum[CREDIT_BITS-1:0];
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) credit <= MAX_EXT[CREDIT_BITS-1:0];
        else          credit <= credit_nxt;
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-limited arbiter sharing the leaf-to-BFT output link.
// Optional LEAF_OUT_ARBITER_STATS_EN adds stall and packet counters.
module leaf_out_arbiter
    import leaf_out_arbiter_pkg::*;
#(
    parameter int NUM_OUT_PORTS         = 6,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int MAX_BURST             = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user,
    output logic [NUM_OUT_PORTS-1:0]              ack_user,
    input  logic                                  cfg_we,
    input  logic [NUM_PORT_BITS-1:0]              cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_dport,
    input  logic [NUM_OUT_PORTS-1:0]              credit_upd,
    input  logic                                  resend,
    output logic [PACKET_BITS-1:0]                pkt_out,
    output logic                                  pkt_vld,
    input  logic                                  pkt_rdy
`ifdef LEAF_OUT_ARBITER_STATS_EN
    ,
    output logic [NUM_OUT_PORTS*16-1:0]           stat_stall,
    output logic [31:0]                           stat_pkts
`endif
);

    localparam int PTR_W   = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    localparam ptr_t LAST_PORT = ptr_t'(NUM_OUT_PORTS - 1);

    arb_state_t           state, state_nxt;
    ptr_t                 grant, grant_nxt, scan_idx, scan_target;
    logic [BURST_W-1:0]   burst_cnt, burst_nxt, burst_inc;
    logic                 scan_found, out_free, accept;
    logic [NUM_OUT_PORTS-1:0] eligible, cfg_hit, cfg_valid;
    logic [NUM_LEAF_BITS-1:0] tbl_leaf  [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] tbl_dport [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] bram_addr [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit    [NUM_OUT_PORTS];
    logic [PACKET_BITS-1:0]   pkt_nxt;

    function automatic ptr_t inc_ptr(input ptr_t p);
        return (p == LAST_PORT) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user[i] && cfg_valid[i] && (credit[i] != '0) && !resend;
            cfg_hit[i]  = cfg_we && (cfg_port == NUM_PORT_BITS'(i));
        end
    end

    assign out_free = !pkt_vld || pkt_rdy;

    // First eligible port after the grant, in round-robin order.
    always_comb begin
        scan_found  = 1'b0;
        scan_target = grant;
        scan_idx    = grant;
        for (int k = 1; k < NUM_OUT_PORTS; k++) begin
            scan_idx = inc_ptr(scan_idx);
            if (!scan_found && eligible[scan_idx]) begin
                scan_found  = 1'b1;
                scan_target = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SCAN;
            grant     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    assign burst_inc = burst_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        burst_nxt = burst_cnt;
        if (!resend) begin
            if (accept) begin
                if (burst_inc == BURST_W'(MAX_BURST)) begin
                    state_nxt = SCAN;
                    grant_nxt = inc_ptr(grant);
                    burst_nxt = '0;
                end else begin
                    state_nxt = HOLD;
                    burst_nxt = burst_inc;
                end
            end else if (!eligible[grant]) begin
                case (state)
                    SCAN: if (scan_found) grant_nxt = scan_target;
                    HOLD: begin
                        state_nxt = SCAN;
                        grant_nxt = inc_ptr(grant);
                        burst_nxt = '0;
                    end
                endcase
            end
        end
    end

    // A config write to the granted port must not race with an accept on it.
    always_comb begin
        ack_user = '0;
        if (eligible[grant] && out_free && !cfg_hit[grant]) ack_user[grant] = 1'b1;
    end

    assign accept = |ack_user;

    always_comb begin
        pkt_nxt            = '0;
        pkt_nxt[VALID_POS] = 1'b1;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant == ptr_t'(i)) begin
                pkt_nxt[LEAF_LSB +: NUM_LEAF_BITS] = tbl_leaf[i];
                pkt_nxt[PORT_LSB +: NUM_PORT_BITS] = tbl_dport[i];
                pkt_nxt[ADDR_LSB +: NUM_ADDR_BITS] = bram_addr[i];
                pkt_nxt[0 +: PAYLOAD_BITS]         = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // NOTE: these per-port tables are small flop arrays, not RAM, so they are
    // reset explicitly; a macro RAM would not be.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_vld   <= 1'b0;
            pkt_out   <= '0;
            cfg_valid <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                tbl_leaf[i]  <= '0;
                tbl_dport[i] <= '0;
                bram_addr[i] <= '0;
            end
        end else begin
            if (accept) begin
                pkt_vld <= 1'b1;
                pkt_out <= pkt_nxt;
            end else if (pkt_rdy) begin
                pkt_vld <= 1'b0;
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (cfg_hit[i]) begin
                    cfg_valid[i] <= 1'b1;
                    tbl_leaf[i]  <= cfg_leaf;
                    tbl_dport[i] <= cfg_dport;
                    bram_addr[i] <= '0;
                end else if (ack_user[i]) begin
                    bram_addr[i] <= bram_addr[i] + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_credit
        leaf_credit_cnt #(
            .UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
        ) u_credit (
            .clk    (clk),
            .reset_n(reset_n),
            .dec    (ack_user[i]),
            .upd    (credit_upd[i]),
            .reload (cfg_hit[i]),
            .credit (credit[i])
        );
    end

`ifdef LEAF_OUT_ARBITER_STATS_EN
    logic [15:0] stall_cnt [NUM_OUT_PORTS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_pkts <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) stall_cnt[i] <= '0;
        end else begin
            if (accept) stat_pkts <= stat_pkts + 1'b1;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (vld_user[i] && !ack_user[i] && (stall_cnt[i] != 16'hFFFF))
                    stall_cnt[i] <= stall_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) stat_stall[i*16 +: 16] = stall_cnt[i];
    end
`endif

endmodule
